// File: rtl/gf_bridge_pkg.sv
// gf_bridge_pkg: op encodings, bridge FSM states and beat-count helper for gf_elem_bridge.
package gf_bridge_pkg;
   typedef enum logic [1:0] {OP_WR = 2'b00, OP_RD = 2'b01, OP_RUN = 2'b10, OP_RSV = 2'b11} op_e;
   typedef enum logic [2:0] {S_IDLE, S_WR_COLLECT, S_WR_COMMIT, S_RD_ISSUE, S_RD_CAPTURE, S_RD_STREAM, S_RUN} state_e;
   function automatic int nbeats(input int w, input int b);
      return (w + b - 1) / b;
   endfunction
endpackage

// File: rtl/gf_elem_bridge_if.sv
// gf_elem_bridge_if: host valid/ready bus and tiny core port bundles.
interface gf_host_if import gf_bridge_pkg::*; #(parameter int BUS_W = 32, parameter int ADDR_W = 6);
   logic              cmd_valid, cmd_ready;
   op_e               cmd_op;
   logic [ADDR_W-1:0] cmd_addr;
   logic              wr_valid, wr_ready;
   logic [BUS_W-1:0]  wr_data;
   logic              rd_valid, rd_ready;
   logic [BUS_W-1:0]  rd_data;
   logic              cmd_err, run_done, busy;
   modport master (output cmd_valid, cmd_op, cmd_addr, wr_valid, wr_data, rd_ready,
                   input cmd_ready, wr_ready, rd_valid, rd_data, cmd_err, run_done, busy);
   modport slave  (input cmd_valid, cmd_op, cmd_addr, wr_valid, wr_data, rd_ready,
                   output cmd_ready, wr_ready, rd_valid, rd_data, cmd_err, run_done, busy);
endinterface

interface gf_core_if #(parameter int WIDTH_D0 = 1187, parameter int ADDR_W = 6);
   logic                core_reset, core_sel, core_w;
   logic [ADDR_W-1:0]   core_addr;
   logic [WIDTH_D0:0]   core_data, core_out;
   logic                core_done;
   modport master (output core_reset, core_sel, core_w, core_addr, core_data, input core_out, core_done);
   modport slave  (input core_reset, core_sel, core_w, core_addr, core_data, output core_out, core_done);
endinterface

// File: rtl/gf_beat_shifter.sv
// gf_beat_shifter: element staging register, loaded whole or one bus beat at a time, read back by beat.
module gf_beat_shifter #(
   parameter int W  = 72,
   parameter int BW = 32,
   parameter int NB = 3,
   parameter int CW = 2
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [CW-1:0] idx_i,
   input  logic          ld_beat_i,
   input  logic [BW-1:0] beat_i,
   input  logic          ld_all_i,
   input  logic [W-1:0]  all_i,
   output logic [W-1:0]  stage_o,
   output logic [BW-1:0] beat_o
);
   localparam int PW = NB * BW;
   logic [PW-1:0] stage_q, ext;
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) stage_q <= '0;
      else if (ld_all_i) stage_q <= PW'(all_i);
      else if (ld_beat_i) stage_q[idx_i*BW +: BW] <= beat_i;
   end
   // bits above the element width never leave the block, in either direction
   assign stage_o = stage_q[W-1:0];
   assign ext     = PW'(stage_o);
   assign beat_o  = ext[idx_i*BW +: BW];
endmodule

// File: rtl/gf_elem_bridge.sv
// gf_elem_bridge: moves GF(3^m) elements between a narrow host bus and tiny's wide port, and sequences runs.
module gf_elem_bridge import gf_bridge_pkg::*; #(
   parameter int WIDTH_D0 = 1187,
   parameter int BUS_W    = 32,
   parameter int ADDR_W   = 6
) (
   input logic     clk,
   input logic     reset,
   gf_host_if.slave host,
   gf_core_if.master core
);
   localparam int W  = WIDTH_D0 + 1;
   localparam int NB = nbeats(W, BUS_W);
   localparam int CW = NB > 1 ? $clog2(NB) : 1;
   state_e            state_q;
   logic [CW-1:0]     ctr_q;
   logic [ADDR_W-1:0] addr_q;
   logic              cmd_ready_q, wr_ready_q, rd_valid_q, cmd_err_q, run_done_q, busy_q;
   logic              core_reset_q, core_sel_q, core_w_q, done_q;
   logic [W-1:0]      stage;
   logic [BUS_W-1:0]  beat;
   logic              last, cmd_acc;
   assign last    = ctr_q == CW'(NB - 1);
   assign cmd_acc = host.cmd_valid & cmd_ready_q;
   gf_beat_shifter #(.W(W), .BW(BUS_W), .NB(NB), .CW(CW)) u_shift (
      .clk      (clk),
      .reset    (reset),
      .idx_i    (ctr_q),
      .ld_beat_i(wr_ready_q & host.wr_valid),
      .beat_i   (host.wr_data),
      .ld_all_i (state_q == S_RD_CAPTURE),
      .all_i    (core.core_out),
      .stage_o  (stage),
      .beat_o   (beat)
   );
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= S_IDLE;
         ctr_q        <= '0;
         addr_q       <= '0;
         cmd_ready_q  <= 1'b1;
         wr_ready_q   <= 1'b0;
         rd_valid_q   <= 1'b0;
         cmd_err_q    <= 1'b0;
         run_done_q   <= 1'b0;
         busy_q       <= 1'b0;
         core_reset_q <= 1'b1;
         core_sel_q   <= 1'b0;
         core_w_q     <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         cmd_err_q  <= 1'b0;
         run_done_q <= 1'b0;
         core_sel_q <= 1'b0;
         core_w_q   <= 1'b0;
         done_q     <= core.core_done;
         case (state_q)
            S_IDLE: if (cmd_acc) begin
               ctr_q <= '0;
               if (host.cmd_op == OP_WR) begin
                  state_q     <= S_WR_COLLECT;
                  addr_q      <= host.cmd_addr;
                  cmd_ready_q <= 1'b0;
                  wr_ready_q  <= 1'b1;
               end else if (host.cmd_op == OP_RD) begin
                  state_q     <= S_RD_ISSUE;
                  addr_q      <= host.cmd_addr;
                  cmd_ready_q <= 1'b0;
                  core_sel_q  <= 1'b1;
               end else if (host.cmd_op == OP_RUN) begin
                  state_q      <= S_RUN;
                  busy_q       <= 1'b1;
                  core_reset_q <= 1'b0;
               end else cmd_err_q <= 1'b1;
            end
            S_WR_COLLECT: if (host.wr_valid) begin
               ctr_q <= last ? '0 : ctr_q + 1'b1;
               if (last) begin
                  state_q    <= S_WR_COMMIT;
                  wr_ready_q <= 1'b0;
                  core_sel_q <= 1'b1;
                  core_w_q   <= 1'b1;
               end
            end
            S_WR_COMMIT: begin
               state_q     <= S_IDLE;
               cmd_ready_q <= 1'b1;
            end
            S_RD_ISSUE: state_q <= S_RD_CAPTURE;
            S_RD_CAPTURE: begin
               state_q    <= S_RD_STREAM;
               rd_valid_q <= 1'b1;
            end
            S_RD_STREAM: if (host.rd_ready) begin
               ctr_q <= last ? '0 : ctr_q + 1'b1;
               if (last) begin
                  state_q     <= S_IDLE;
                  rd_valid_q  <= 1'b0;
                  cmd_ready_q <= 1'b1;
               end
            end
            S_RUN: begin
               // commands stay acceptable so the host never stalls, but each one is refused
               cmd_err_q <= cmd_acc;
               if (core.core_done && !done_q) begin
                  state_q      <= S_IDLE;
                  busy_q       <= 1'b0;
                  core_reset_q <= 1'b1;
                  run_done_q   <= 1'b1;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end
   assign host.cmd_ready = cmd_ready_q;
   assign host.wr_ready  = wr_ready_q;
   assign host.rd_valid  = rd_valid_q;
   assign host.rd_data   = rd_valid_q ? beat : '0;
   assign host.cmd_err   = cmd_err_q;
   assign host.run_done  = run_done_q;
   assign host.busy      = busy_q;
   assign core.core_reset = core_reset_q;
   assign core.core_sel   = core_sel_q;
   assign core.core_w     = core_w_q;
   assign core.core_addr  = addr_q;
   assign core.core_data  = stage;
endmodule

// File: tb/tb_gf_elem_bridge.sv
// tb_gf_elem_bridge: directed checks of gf_elem_bridge in a 72-bit and the default 1188-bit configuration.
module tb_gf_elem_bridge;
   import gf_bridge_pkg::*;
   logic clk = 1'b0, rst_n = 1'b0;
   int tests = 0, fails = 0;
   logic [1215:0] xp, tmp;
   always #5 clk = ~clk;
   gf_host_if #(.BUS_W(32), .ADDR_W(6)) hs();
   gf_core_if #(.WIDTH_D0(71), .ADDR_W(6)) cs();
   gf_host_if #(.BUS_W(32), .ADDR_W(6)) hb();
   gf_core_if #(.WIDTH_D0(1187), .ADDR_W(6)) cb();
   gf_elem_bridge #(.WIDTH_D0(71), .BUS_W(32), .ADDR_W(6)) u_small (
      .clk(clk), .reset(rst_n), .host(hs.slave), .core(cs.master));
   gf_elem_bridge #(.WIDTH_D0(1187), .BUS_W(32), .ADDR_W(6)) u_big (
      .clk(clk), .reset(rst_n), .host(hb.slave), .core(cb.master));
   function automatic logic [31:0] gen(input int i);
      return 32'h9E3779B9 * 32'(i + 1);
   endfunction
   task automatic step(input int n = 1);
      repeat (n) @(negedge clk);
   endtask
   task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   task automatic cmd(input op_e op, input logic [5:0] addr);
      hs.cmd_valid = 1'b1;
      hs.cmd_op    = op;
      hs.cmd_addr  = addr;
      step();
      hs.cmd_valid = 1'b0;
   endtask
   initial begin
      hs.cmd_valid = 0; hs.cmd_op = OP_WR; hs.cmd_addr = 0; hs.wr_valid = 0; hs.wr_data = 0; hs.rd_ready = 0;
      hb.cmd_valid = 0; hb.cmd_op = OP_WR; hb.cmd_addr = 0; hb.wr_valid = 0; hb.wr_data = 0; hb.rd_ready = 0;
      cs.core_out = '0; cs.core_done = 0; cb.core_out = '0; cb.core_done = 0;
      step(2);
      chk("rst_ctl", 72'({hs.cmd_ready, hs.wr_ready, hs.rd_valid, hs.cmd_err, hs.run_done, hs.busy,
                          cs.core_reset, cs.core_sel, cs.core_w}), 72'b1_0000_0100);
      chk("rst_rd_data", 72'(hs.rd_data), 72'h0);
      chk("rst_core_addr", 72'(cs.core_addr), 72'h0);
      chk("rst_core_data", cs.core_data, 72'h0);
      chk("rst_big_ctl", 72'({hb.cmd_ready, cb.core_reset, cb.core_sel}), 72'b110);
      rst_n = 1'b1;
      step();
      // small write: three beats then a single commit cycle
      cmd(OP_WR, 6'd3);
      chk("wr_ready_on", 72'({hs.wr_ready, hs.cmd_ready}), 72'b10);
      hs.wr_valid = 1'b1;
      hs.wr_data = 32'h89abcdef; step();
      chk("wr_no_sel_mid", 72'(cs.core_sel), 72'h0);
      hs.wr_data = 32'h01234567; step();
      hs.wr_data = 32'hffffffa5; step();
      hs.wr_valid = 1'b0;
      chk("wr_commit_ctl", 72'({cs.core_sel, cs.core_w, hs.wr_ready}), 72'b110);
      chk("wr_commit_addr", 72'(cs.core_addr), 72'd3);
      chk("wr_commit_data", cs.core_data, 72'ha5_01234567_89abcdef);
      step();
      chk("wr_commit_end", 72'({cs.core_sel, cs.core_w, hs.cmd_ready}), 72'b001);
      // small read with a 5-cycle stall on beat 1
      cs.core_out = 72'ha5_01234567_89abcdef;
      cmd(OP_RD, 6'd3);
      chk("rd_issue", 72'({cs.core_sel, cs.core_w, hs.rd_valid, hs.cmd_ready}), 72'b1000);
      chk("rd_issue_addr", 72'(cs.core_addr), 72'd3);
      step();
      chk("rd_capture", 72'({cs.core_sel, hs.rd_valid}), 72'b00);
      step();
      cs.core_out = '0;
      chk("rd_beat0", 72'({hs.rd_valid, hs.rd_data}), {39'd0, 1'b1, 32'h89abcdef});
      hs.rd_ready = 1'b1;
      step();
      hs.rd_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         chk($sformatf("rd_stall%0d", i), 72'({hs.rd_valid, hs.rd_data}), {39'd0, 1'b1, 32'h01234567});
         step();
      end
      hs.rd_ready = 1'b1;
      step();
      chk("rd_beat2", 72'({hs.rd_valid, hs.rd_data}), {39'd0, 1'b1, 32'h000000a5});
      step();
      hs.rd_ready = 1'b0;
      chk("rd_done", 72'({hs.rd_valid, hs.cmd_ready, hs.rd_data}), {38'd0, 2'b01, 32'h0});
      // run with a refused read while busy
      cmd(OP_RUN, 6'd0);
      chk("run_start", 72'({cs.core_reset, hs.busy, hs.cmd_ready, cs.core_sel}), 72'b0110);
      cmd(OP_RD, 6'd2);
      chk("run_refuse", 72'({hs.cmd_err, cs.core_sel, hs.busy}), 72'b101);
      step();
      chk("run_err_pulse", 72'({hs.cmd_err, hs.busy, cs.core_reset}), 72'b010);
      cs.core_done = 1'b1;
      step();
      chk("run_done", 72'({hs.run_done, cs.core_reset, hs.busy}), 72'b110);
      step();
      chk("run_done_pulse", 72'({hs.run_done, hs.cmd_ready, hs.busy}), 72'b010);
      cs.core_done = 1'b0;
      // reserved op refused in IDLE with nothing else disturbed
      cmd(OP_RSV, 6'd9);
      chk("rsv_err", 72'({hs.cmd_err, hs.cmd_ready, hs.wr_ready, hs.rd_valid, hs.busy}), 72'b11000);
      chk("rsv_addr_kept", 72'(cs.core_addr), 72'd3);
      step();
      chk("rsv_err_pulse", 72'(hs.cmd_err), 72'h0);
      // reset after two beats discards the partial element
      cmd(OP_WR, 6'd5);
      hs.wr_valid = 1'b1;
      hs.wr_data = 32'h11111111; step();
      hs.wr_data = 32'h22222222; step();
      hs.wr_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("midrst_ctl", 72'({cs.core_sel, hs.wr_ready, hs.cmd_ready, cs.core_reset}), 72'b0011);
      chk("midrst_data", cs.core_data, 72'h0);
      step();
      rst_n = 1'b1;
      step(2);
      chk("midrst_after", 72'({cs.core_sel, cs.core_addr}), 72'h0);
      cmd(OP_WR, 6'd7);
      hs.wr_valid = 1'b1;
      hs.wr_data = 32'h00000001; step();
      hs.wr_data = 32'h00000002; step();
      hs.wr_data = 32'h00000003; step();
      hs.wr_valid = 1'b0;
      chk("wr2_commit", 72'({cs.core_sel, cs.core_w, cs.core_addr}), {64'd0, 2'b11, 6'd7});
      chk("wr2_data", cs.core_data, 72'h03_00000002_00000001);
      step();
      // default config: 38-beat write then read back
      xp = '0;
      for (int i = 0; i < 38; i++) xp[i*32 +: 32] = gen(i);
      xp[1215:1188] = '0;
      hb.cmd_valid = 1'b1; hb.cmd_op = OP_WR; hb.cmd_addr = 6'd1;
      step();
      hb.cmd_valid = 1'b0;
      hb.wr_valid = 1'b1;
      for (int i = 0; i < 38; i++) begin
         hb.wr_data = gen(i);
         step();
      end
      hb.wr_valid = 1'b0;
      chk("big_commit", 72'({cb.core_sel, cb.core_w, cb.core_addr}), {64'd0, 2'b11, 6'd1});
      tmp = 1216'(cb.core_data);
      for (int i = 0; i < 38; i++) chk($sformatf("big_wr%0d", i), 72'(tmp[i*32 +: 32]), 72'(xp[i*32 +: 32]));
      step();
      cb.core_out = xp[1187:0];
      hb.cmd_valid = 1'b1; hb.cmd_op = OP_RD; hb.cmd_addr = 6'd1;
      step();
      hb.cmd_valid = 1'b0;
      step(2);
      cb.core_out = '0;
      hb.rd_ready = 1'b1;
      for (int i = 0; i < 38; i++) begin
         chk($sformatf("big_rd%0d", i), 72'({hb.rd_valid, hb.rd_data}), {39'd0, 1'b1, xp[i*32 +: 32]});
         step();
      end
      hb.rd_ready = 1'b0;
      chk("big_rd_end", 72'({hb.rd_valid, hb.cmd_ready}), 72'b01);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
